// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-in/parallel-out receiver.
package shift_deser_pkg;

  typedef enum logic [0:0] {
    DESER_IDLE  = 1'b0,
    DESER_SHIFT = 1'b1
  } deser_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/frame_bit_counter.sv
// Frame bit counter: synchronous clear, increment, and terminal-count flag.
module frame_bit_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CW        = $clog2(FRAME_LEN + 2)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [CW-1:0] count_r;

  // Count accepted frame bits; saturates at the final position instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (inc && !last) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign last = (count_r == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/shift_deserializer.sv
// Serial-in, parallel-out receiver with valid/ready output and overrun flag.
// Define SHIFT_DESER_PARITY_EN to append one even-parity bit to each frame.
module shift_deserializer
  import shift_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             dir,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SHIFT_DESER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);

  deser_state_t     state_r;
  logic             dir_r;
  logic [WIDTH-1:0] shift_r;
  logic [WIDTH-1:0] data_r;
  logic             out_valid_r;
  logic             busy_r;
  logic             overrun_r;
  logic             parity_err_r;

  logic             frame_bit_s;
  logic             clr_s;
  logic             last_s;
  logic [WIDTH-1:0] shift_next_s;
  logic [WIDTH-1:0] word_s;
  logic             word_par_s;

  frame_bit_counter #(
    .FRAME_LEN (FRAME_LEN),
    .CW        (CW)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .inc  (frame_bit_s),
    .last (last_s)
  );

  // Bit acceptance, counter clear and the word candidate for completion.
  always_comb begin
    frame_bit_s  = (state_r == DESER_SHIFT) && bit_valid && !start;
    clr_s        = start || (frame_bit_s && last_s);
    shift_next_s = shift_r;
    if (dir_r == DIR_LSB_FIRST) begin
      shift_next_s = {bit_in, shift_r[WIDTH-1:1]};
    end else begin
      shift_next_s = {shift_r[WIDTH-2:0], bit_in};
    end
`ifdef SHIFT_DESER_PARITY_EN
    // The trailing bit is parity, so the data word is already complete.
    word_s     = shift_r;
    word_par_s = even_parity(shift_r) ^ bit_in;
`else
    word_s     = shift_next_s;
    word_par_s = 1'b0;
`endif
  end

  // Frame FSM, shift register and output holding register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= DESER_IDLE;
      dir_r        <= DIR_MSB_FIRST;
      shift_r      <= '0;
      data_r       <= '0;
      out_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      parity_err_r <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      if (out_valid_r && out_ready) begin
        out_valid_r <= 1'b0;
      end
      case (state_r)
        DESER_IDLE: begin
          if (start) begin
            state_r <= DESER_SHIFT;
            busy_r  <= 1'b1;
            shift_r <= '0;
            dir_r   <= dir;
          end
        end
        DESER_SHIFT: begin
          if (start) begin
            shift_r <= '0;
            dir_r   <= dir;
          end else if (bit_valid) begin
            shift_r <= shift_next_s;
            if (last_s) begin
              state_r <= DESER_IDLE;
              busy_r  <= 1'b0;
              if (!out_valid_r || out_ready) begin
                data_r       <= word_s;
                out_valid_r  <= 1'b1;
                parity_err_r <= word_par_s;
              end else begin
                overrun_r <= 1'b1;
              end
            end
          end
        end
        default: begin
          state_r <= DESER_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = data_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;
  assign overrun    = overrun_r;
  assign parity_err = parity_err_r;

endmodule
